// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

   // Display modes, in the order a mode press cycles through them.
   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'd0,
      MODE_ROT_R  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   // Direction of travel of the lit LED in bounce mode.
   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   // Pattern constants are held wide; the top slices them to LED_W (max 32).
   localparam int PAT_MAX_W = 32;
   localparam logic [PAT_MAX_W-1:0] PAT_ONEHOT_INIT = 32'h0000_0001;
   localparam logic [PAT_MAX_W-1:0] PAT_ALL_ON      = 32'hFFFF_FFFF;
   localparam logic [PAT_MAX_W-1:0] LED_OFF_ALL     = 32'hFFFF_FFFF;

   // Mode that follows m on a mode press.
   function automatic mode_t next_mode(input mode_t m);
      mode_t r;
      case (m)
         MODE_ROT_L:  r = MODE_ROT_R;
         MODE_ROT_R:  r = MODE_BOUNCE;
         MODE_BOUNCE: r = MODE_BLINK;
         default:     r = MODE_ROT_L;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, level debounce and a
// one-cycle press pulse on each accepted press (1 -> 0) of the button.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 270_000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic btn_n,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic             press_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Bring the raw asynchronous button into the sys_clk domain.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= btn_n;
         sync2_reg <= sync1_reg;
      end
   end

   // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         level_reg <= 1'b1;
         cnt_reg   <= '0;
         press_reg <= 1'b0;
      end else begin
         press_reg <= 1'b0;
         if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= sync2_reg;
            press_reg <= ~sync2_reg;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Button-driven LED pattern sequencer: mode/speed buttons, step tick
// generator and a pattern engine driving active-low LED pins.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int LED_W           = 6,
   parameter int TICK_CYCLES     = 1_350_000,
   parameter int DEBOUNCE_CYCLES = 270_000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             btn_mode_n,
   input  logic             btn_speed_n,
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic [1:0]       speed,
   output logic             step_tick
);

   localparam int CNT_W = $clog2(TICK_CYCLES + 1);
   localparam logic [CNT_W-1:0] TICK_PERIOD = CNT_W'(TICK_CYCLES);
   localparam logic [LED_W-1:0] P_ONEHOT = PAT_ONEHOT_INIT[LED_W-1:0];
   localparam logic [LED_W-1:0] P_ALL_ON = PAT_ALL_ON[LED_W-1:0];
   localparam logic [LED_W-1:0] L_OFF    = LED_OFF_ALL[LED_W-1:0];

   // Bit 0 = mode button, bit 1 = speed button.
   logic [1:0] btn_raw_n;
   logic [1:0] press_vec;
   logic       mode_press;
   logic       speed_press;
   logic       any_press;

   assign btn_raw_n   = {btn_speed_n, btn_mode_n};
   assign mode_press  = press_vec[0];
   assign speed_press = press_vec[1];
   assign any_press   = mode_press | speed_press;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_btn (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .btn_n   (btn_raw_n[gi]),
            .press   (press_vec[gi])
         );
      end
   endgenerate

   logic [1:0]       speed_reg;
   logic [CNT_W-1:0] tick_cnt_reg;
   logic             step_tick_reg;
   logic [CNT_W-1:0] period;

   // Faster speeds halve the step period each time.
   assign period = TICK_PERIOD >> speed_reg;

   // Speed index advances on each speed press, wrapping 3 -> 0.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         speed_reg <= 2'd0;
      end else if (speed_press) begin
         speed_reg <= speed_reg + 2'd1;
      end
   end

   // Step tick generator; any press restarts the period from zero.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tick_cnt_reg  <= '0;
         step_tick_reg <= 1'b0;
      end else if (any_press) begin
         tick_cnt_reg  <= '0;
         step_tick_reg <= 1'b0;
      end else if (tick_cnt_reg == period - 1'b1) begin
         tick_cnt_reg  <= '0;
         step_tick_reg <= 1'b1;
      end else begin
         tick_cnt_reg  <= tick_cnt_reg + 1'b1;
         step_tick_reg <= 1'b0;
      end
   end

   mode_t            mode_reg,  mode_next;
   dir_t             dir_reg,   dir_next;
   logic [LED_W-1:0] p_reg,     p_next;
   logic [LED_W-1:0] led_reg,   led_next;

   // Mode, direction, pattern and LED pin registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mode_reg <= MODE_ROT_L;
         dir_reg  <= DIR_LEFT;
         p_reg    <= P_ONEHOT;
         led_reg  <= L_OFF ^ P_ONEHOT;
      end else begin
         mode_reg <= mode_next;
         dir_reg  <= dir_next;
         p_reg    <= p_next;
         led_reg  <= led_next;
      end
   end

   // Next mode/pattern: a press reloads (and suppresses a coincident step).
   always_comb begin
      mode_next = mode_reg;
      dir_next  = dir_reg;
      p_next    = p_reg;
      if (mode_press) begin
         mode_next = next_mode(mode_reg);
         dir_next  = DIR_LEFT;
         p_next    = (next_mode(mode_reg) == MODE_BLINK) ? P_ALL_ON : P_ONEHOT;
      end else if (speed_press) begin
         p_next = p_reg;
      end else if (step_tick_reg) begin
         case (mode_reg)
            MODE_ROT_L: p_next = {p_reg[LED_W-2:0], p_reg[LED_W-1]};
            MODE_ROT_R: p_next = {p_reg[0], p_reg[LED_W-1:1]};
            MODE_BOUNCE: begin
               if (dir_reg == DIR_LEFT) begin
                  if (p_reg[LED_W-1]) begin
                     p_next   = {1'b0, p_reg[LED_W-1:1]};
                     dir_next = DIR_RIGHT;
                  end else begin
                     p_next = {p_reg[LED_W-2:0], 1'b0};
                  end
               end else begin
                  if (p_reg[0]) begin
                     p_next   = {p_reg[LED_W-2:0], 1'b0};
                     dir_next = DIR_LEFT;
                  end else begin
                     p_next = {1'b0, p_reg[LED_W-1:1]};
                  end
               end
            end
            default: p_next = ~p_reg;
         endcase
      end
      led_next = L_OFF ^ p_next;
   end

   assign led       = led_reg;
   assign mode      = mode_reg;
   assign speed     = speed_reg;
   assign step_tick = step_tick_reg;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed button stimulus, expected events
// queued by the stimulus, checked by an independent negedge monitor.
module tb_led_pattern_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       btn_mode_n;
   logic       btn_speed_n;
   logic [5:0] led;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       step_tick;

   led_pattern_ctrl #(
      .LED_W           (6),
      .TICK_CYCLES     (16),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .btn_mode_n  (btn_mode_n),
      .btn_speed_n (btn_speed_n),
      .led         (led),
      .mode        (mode),
      .speed       (speed),
      .step_tick   (step_tick)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit         is_press;
      logic [5:0] led;
      logic [1:0] mode;
      logic [1:0] speed;
      int         gap;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   bit   pending  = 0;
   int   tick_gap = 0;
   int   last_evt = 0;
   logic [1:0] prev_mode  = 2'd0;
   logic [1:0] prev_speed = 2'd0;

   // Hand-computed LED pins for the 11 bounce steps after the reload.
   logic [5:0] bounce_led [11] = '{6'b111101, 6'b111011, 6'b110111, 6'b101111,
                                   6'b011111, 6'b101111, 6'b110111, 6'b111011,
                                   6'b111101, 6'b111110, 6'b111101};

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic void push_ev(bit p, logic [5:0] l, logic [1:0] m,
                                   logic [1:0] s, int g);
      exp_t e;
      e.is_press = p; e.led = l; e.mode = m; e.speed = s; e.gap = g;
      exp_q.push_back(e);
   endfunction

   task automatic check_val(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 'h%0h required 'h%0h", name, act, req);
      end
   endtask

   task automatic check_ev(bit is_press, int gap);
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: press=%0d led=%b mode=%0d speed=%0d at cyc %0d",
                  is_press, led, mode, speed, cyc);
         return;
      end
      e = exp_q.pop_front();
      if (e.is_press != is_press || led !== e.led || mode !== e.mode ||
          speed !== e.speed || (e.gap != 0 && gap != e.gap)) begin
         n_err++;
         $display("FAIL event: got press=%0d led=%b mode=%0d speed=%0d gap=%0d required press=%0d led=%b mode=%0d speed=%0d gap=%0d",
                  is_press, led, mode, speed, gap, e.is_press, e.led, e.mode, e.speed, e.gap);
      end else begin
         $display("event ok: press=%0d led=%b mode=%0d speed=%0d gap=%0d",
                  is_press, led, mode, speed, gap);
      end
   endtask

   // Monitor: a mode/speed change is a press event; the cycle after a
   // step_tick is a step event. A press right after a tick absorbs it.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (sys_rst) begin
            prev_mode  = mode;
            prev_speed = speed;
            pending    = 0;
            last_evt   = cyc;
         end else begin
            if (mode !== prev_mode || speed !== prev_speed) begin
               check_ev(1'b1, 0);
               pending  = 0;
               last_evt = cyc;
            end else if (pending) begin
               check_ev(1'b0, tick_gap);
               pending = 0;
            end
            if (step_tick) begin
               tick_gap = cyc - last_evt;
               last_evt = cyc;
               pending  = 1;
            end
            prev_mode  = mode;
            prev_speed = speed;
         end
      end
   end

   task automatic wait_tick();
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (step_tick) return;
      end
      n_checks++;
      n_err++;
      $display("FAIL wait_tick: got no step_tick within 100 cycles required one");
   endtask

   // Hold the chosen buttons low for 'hold' cycles from this negedge;
   // the outputs change 7 negedges later (press pulse at cycle 6).
   task automatic drive_btns(bit use_mode, bit use_speed, int hold);
      logic [1:0] m0, s0;
      int lat;
      m0 = mode; s0 = speed; lat = 0;
      #1;
      if (use_mode)  btn_mode_n  = 1'b0;
      if (use_speed) btn_speed_n = 1'b0;
      for (int i = 1; i <= hold; i++) begin
         @(negedge sys_clk);
         if (lat == 0 && (mode !== m0 || speed !== s0)) lat = i;
      end
      #1;
      btn_mode_n  = 1'b1;
      btn_speed_n = 1'b1;
      check_val("press_latency", lat, 7);
   endtask

   initial begin
      sys_rst = 1'b1; btn_mode_n = 1'b1; btn_speed_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      check_val("rst_led", led, 6'b111110);
      check_val("rst_mode", mode, 0);
      check_val("rst_speed", speed, 0);
      check_val("rst_tick", step_tick, 0);

      // ROT_L at speed 0, four steps plus the one before the real press.
      push_ev(0, 6'b111101, 0, 0, 16);
      push_ev(0, 6'b111011, 0, 0, 16);
      push_ev(0, 6'b110111, 0, 0, 16);
      push_ev(0, 6'b101111, 0, 0, 16);
      push_ev(0, 6'b011111, 0, 0, 16);
      #1 sys_rst = 1'b0;
      repeat (4) wait_tick();

      // 3-cycle glitch must not be accepted.
      #1 btn_mode_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      #1 btn_mode_n = 1'b1;
      wait_tick();
      check_val("glitch_mode", mode, 0);

      // Real press, held 10 cycles -> ROT_R.
      push_ev(1, 6'b111110, 1, 0, 0);
      push_ev(0, 6'b011111, 1, 0, 16);
      push_ev(0, 6'b101111, 1, 0, 16);
      drive_btns(1, 0, 10);
      repeat (2) wait_tick();

      // BOUNCE for 11 steps.
      push_ev(1, 6'b111110, 2, 0, 0);
      for (int i = 0; i < 11; i++) push_ev(0, bounce_led[i], 2, 0, 16);
      drive_btns(1, 0, 7);
      repeat (11) wait_tick();

      // BLINK.
      push_ev(1, 6'b000000, 3, 0, 0);
      push_ev(0, 6'b111111, 3, 0, 16);
      push_ev(0, 6'b000000, 3, 0, 16);
      drive_btns(1, 0, 7);
      repeat (2) wait_tick();

      // Fourth press wraps to ROT_L.
      push_ev(1, 6'b111110, 0, 0, 0);
      push_ev(0, 6'b111101, 0, 0, 16);
      drive_btns(1, 0, 7);
      wait_tick();

      // Speed 1: period 8.
      push_ev(1, 6'b111101, 0, 1, 0);
      push_ev(0, 6'b111011, 0, 1, 8);
      drive_btns(0, 1, 7);
      wait_tick();

      // Speed 2: period 4.
      push_ev(1, 6'b111011, 0, 2, 0);
      push_ev(0, 6'b110111, 0, 2, 4);
      push_ev(0, 6'b101111, 0, 2, 4);
      drive_btns(0, 1, 7);
      repeat (2) wait_tick();

      // Speed 3: period 2; one step lands inside the debounce window.
      push_ev(0, 6'b011111, 0, 2, 4);
      push_ev(1, 6'b011111, 0, 3, 0);
      push_ev(0, 6'b111110, 0, 3, 2);
      push_ev(0, 6'b111101, 0, 3, 2);
      push_ev(0, 6'b111011, 0, 3, 2);
      push_ev(0, 6'b110111, 0, 3, 2);
      drive_btns(0, 1, 7);
      repeat (4) wait_tick();

      // Wrap to speed 0; the third tick coincides with the press and is dropped.
      push_ev(0, 6'b101111, 0, 3, 2);
      push_ev(0, 6'b011111, 0, 3, 2);
      push_ev(1, 6'b011111, 0, 0, 0);
      push_ev(0, 6'b111110, 0, 0, 16);
      drive_btns(0, 1, 7);
      wait_tick();

      // Both presses land exactly on a step_tick: reload, no step.
      push_ev(1, 6'b111110, 1, 1, 0);
      push_ev(0, 6'b011111, 1, 1, 8);
      repeat (10) @(negedge sys_clk);
      #1; btn_mode_n = 1'b0; btn_speed_n = 1'b0;
      repeat (6) @(negedge sys_clk);
      check_val("tick_coincide", step_tick, 1);
      @(negedge sys_clk);
      #1; btn_mode_n = 1'b1; btn_speed_n = 1'b1;
      wait_tick();

      // Asynchronous reset mid-stream.
      repeat (3) @(negedge sys_clk);
      #1 sys_rst = 1'b1;
      #1;
      check_val("midrst_led", led, 6'b111110);
      check_val("midrst_mode", mode, 0);
      check_val("midrst_speed", speed, 0);
      check_val("midrst_tick", step_tick, 0);
      repeat (2) @(negedge sys_clk);
      push_ev(0, 6'b111101, 0, 0, 16);
      #1 sys_rst = 1'b0;
      wait_tick();

      for (int i = 0; i < 64 && (exp_q.size() != 0 || pending); i++) @(negedge sys_clk);
      check_val("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
